// File: rtl/axi_lite_initiator_if.sv
// Core request/response and AXI4-Lite signal bundle for axi_lite_initiator.
// The master modport is the initiator's view; slave is the core + interconnect side.
interface axi_lite_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic [2:0]  axi_arprot;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic [2:0]  axi_awprot;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output axi_araddr, axi_arvalid, axi_arprot,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  axi_araddr, axi_arvalid, axi_arprot,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready
    );
endinterface

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: one core load/store becomes one AR/R or AW/W/B
// transaction. Every output except req_ready is a flop; none reacts combinationally to AXI inputs.
//
//   state   | meaning
//   IDLE    | ready for a core request
//   RD_ADDR | arvalid high, waiting for arready
//   RD_DATA | rready high, waiting for rvalid
//   WR_REQ  | awvalid/wvalid raised, each drops after its own handshake
//   WR_RESP | bready high, waiting for bvalid
module axi_lite_initiator (
    input  logic                 clk,
    input  logic                 rstn,
    axi_lite_initiator_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_both;

    assign ar_hs   = arvalid_q & bus.axi_arready;
    assign r_hs    = rready_q  & bus.axi_rvalid;
    assign aw_hs   = awvalid_q & bus.axi_awready;
    assign w_hs    = wvalid_q  & bus.axi_wready;
    assign b_hs    = bready_q  & bus.axi_bvalid;
    // Both write handshakes done, counting any that complete this cycle.
    assign wr_both = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = bus.req_we ? WR_REQ : RD_ADDR;
            RD_ADDR: if (ar_hs)         state_d = RD_DATA;
            RD_DATA: if (r_hs)          state_d = IDLE;
            WR_REQ:  if (wr_both)       state_d = WR_RESP;
            WR_RESP: if (b_hs)          state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (bus.req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus.axi_rdata;
                    resp_err_d   = bus.axi_rresp[1];
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (wr_both) bready_d = 1'b1;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = bus.axi_bresp[1];
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arprot  = 3'b000;
    assign bus.axi_rready  = rready_q;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_awprot  = 3'b000;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = wstrb_q;
    assign bus.axi_wvalid  = wvalid_q;
    assign bus.axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: a memory-backed AXI slave with optional random stalls, and a
// word-memory reference model that predicts every response from the core-side request alone.
module tb_axi_lite_initiator;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_lite_initiator_if bus ();

    axi_lite_initiator dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs, set by the stimulus process.
    bit         rnd_mode   = 1'b0;
    int         aw_delay   = 0;
    bit         force_en   = 1'b0;
    logic [1:0] force_code = 2'b00;
    int         last_aw_hi = 0;
    int         last_w_hi  = 0;

    // Address map: 0xF.. SLVERR, 0xE.. DECERR, 0xD.. EXOKAY, everything else OKAY.
    function automatic logic [1:0] resp_code(input logic [31:0] a);
        if (force_en) return force_code;
        case (a[31:28])
            4'hF:    return 2'b10;
            4'hE:    return 2'b11;
            4'hD:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] mem_init(input int i);
        return 32'h12345678 ^ (32'(i ^ 14) * 32'h11111111);
    endfunction

    // ---------------- AXI slave ----------------
    logic [31:0] smem [16];
    initial begin
        logic        rd_pending, aw_got, w_got;
        logic        ar_f, aw_f, w_f, r_f, b_f;
        logic        p_arv, p_awv, p_wv;
        logic [31:0] rd_addr, aw_addr_c, w_data_c, p_araddr, p_awaddr, p_wdata;
        logic [3:0]  w_strb_c, p_wstrb;
        int          aw_hi, w_hi;
        for (int i = 0; i < 16; i++) smem[i] = mem_init(i);
        bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0; bus.axi_rresp = '0;
        bus.axi_awready = 1'b0; bus.axi_wready = 1'b0; bus.axi_bvalid = 1'b0; bus.axi_bresp = '0;
        rd_pending = 0; aw_got = 0; w_got = 0; ar_f = 0; aw_f = 0; w_f = 0; r_f = 0; b_f = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; aw_hi = 0; w_hi = 0;
        rd_addr = '0; aw_addr_c = '0; w_data_c = '0; w_strb_c = '0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_awready = 1'b0;
                bus.axi_wready = 1'b0; bus.axi_bvalid = 1'b0;
                rd_pending = 0; aw_got = 0; w_got = 0; ar_f = 0; aw_f = 0; w_f = 0;
                r_f = 0; b_f = 0; p_arv = 0; p_awv = 0; p_wv = 0; aw_hi = 0; w_hi = 0;
                continue;
            end
            if (p_arv && !ar_f) begin
                chk("arvalid_held", 32'(bus.axi_arvalid), 32'd1);
                chk("araddr_stable", bus.axi_araddr, p_araddr);
            end
            if (p_awv && !aw_f) begin
                chk("awvalid_held", 32'(bus.axi_awvalid), 32'd1);
                chk("awaddr_stable", bus.axi_awaddr, p_awaddr);
            end
            if (p_wv && !w_f) begin
                chk("wvalid_held", 32'(bus.axi_wvalid), 32'd1);
                chk("wdata_stable", bus.axi_wdata, p_wdata);
                chk("wstrb_stable", 32'(bus.axi_wstrb), 32'(p_wstrb));
            end
            if (r_f) bus.axi_rvalid = 1'b0;
            if (b_f) bus.axi_bvalid = 1'b0;
            chk("rready_unsolicited", 32'(bus.axi_rready && !(rd_pending || bus.axi_rvalid)), 32'd0);
            chk("bready_early", 32'(bus.axi_bready && !((aw_got && w_got) || bus.axi_bvalid)), 32'd0);
            if (rd_pending && !bus.axi_rvalid && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                bus.axi_rvalid = 1'b1;
                bus.axi_rdata  = smem[rd_addr[5:2]];
                bus.axi_rresp  = resp_code(rd_addr);
                rd_pending = 0;
            end
            if (aw_got && w_got && !bus.axi_bvalid && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_c[b]) smem[aw_addr_c[5:2]][8*b +: 8] = w_data_c[8*b +: 8];
                bus.axi_bvalid = 1'b1;
                bus.axi_bresp  = resp_code(aw_addr_c);
                aw_got = 0; w_got = 0;
            end
            if (bus.axi_awvalid) aw_hi++;
            if (bus.axi_wvalid) w_hi++;
            bus.axi_arready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axi_wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.axi_awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'(aw_hi >= aw_delay);
            ar_f = bus.axi_arvalid && bus.axi_arready;
            aw_f = bus.axi_awvalid && bus.axi_awready;
            w_f  = bus.axi_wvalid && bus.axi_wready;
            r_f  = bus.axi_rvalid && bus.axi_rready;
            b_f  = bus.axi_bvalid && bus.axi_bready;
            if (ar_f) begin rd_pending = 1; rd_addr = bus.axi_araddr; end
            if (aw_f) begin aw_got = 1; aw_addr_c = bus.axi_awaddr; last_aw_hi = aw_hi; aw_hi = 0; end
            if (w_f) begin
                w_got = 1; w_data_c = bus.axi_wdata; w_strb_c = bus.axi_wstrb;
                last_w_hi = w_hi; w_hi = 0;
            end
            p_arv = bus.axi_arvalid; p_araddr = bus.axi_araddr;
            p_awv = bus.axi_awvalid; p_awaddr = bus.axi_awaddr;
            p_wv  = bus.axi_wvalid;  p_wdata  = bus.axi_wdata; p_wstrb = bus.axi_wstrb;
        end
    end

    // ---------------- response monitor ----------------
    int resp_cnt = 0;
    initial begin
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && bus.resp_valid) begin
                resp_cnt++;
                chk("resp_valid_one_cycle", 32'(prev_rv), 32'd0);
            end
            prev_rv = rstn && bus.resp_valid;
        end
    end

    // ---------------- reference model and stimulus ----------------
    logic [31:0] mmem [16];
    int          n_req = 0;
    logic        have_last = 1'b0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    task automatic model_txn(input logic we, input logic [31:0] a, wd, input logic [3:0] ws,
                             output logic [31:0] exp_rd, output logic exp_err);
        logic [1:0]  code;
        logic [31:0] mask;
        code    = resp_code(a);
        exp_err = (code == 2'b10) || (code == 2'b11);
        if (we) begin
            mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
            mmem[a[5:2]] = (mmem[a[5:2]] & ~mask) | (wd & mask);
            exp_rd = '0;
        end else begin
            exp_rd = mmem[a[5:2]];
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic we, input logic [31:0] a, wd, input logic [3:0] ws,
                         output logic ar1, output logic aw1, output logic w1);
        int i;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
        bus.req_wdata = wd; bus.req_wstrb = ws;
        for (i = 0; i < 200; i++) begin
            if (bus.req_ready) break;
            @(negedge clk);
        end
        chk("req_accept_timeout", 32'(i < 200), 32'd1);
        @(negedge clk);
        ar1 = bus.axi_arvalid; aw1 = bus.axi_awvalid; w1 = bus.axi_wvalid;
        // Garbage on the request port while busy must be ignored.
        bus.req_valid = 1'($urandom_range(0, 1)); bus.req_we = 1'($urandom_range(0, 1));
        bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_wstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic err, output int lat);
        logic found;
        found = 1'b0;
        lat = 1;
        for (int i = 0; i < 400; i++) begin
            if (bus.resp_valid) begin found = 1'b1; break; end
            if (have_last) begin
                chk("resp_rdata_hold", bus.resp_rdata, last_rd);
                chk("resp_err_hold", 32'(bus.resp_err), 32'(last_err));
            end
            @(negedge clk);
            lat++;
        end
        chk("resp_timeout", 32'(found), 32'd1);
        rd = bus.resp_rdata; err = bus.resp_err;
        chk("req_ready_at_resp", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        last_rd = rd; last_err = err; have_last = 1'b1;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] a, wd, input logic [3:0] ws,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic ar1, output logic aw1, output logic w1);
        logic [31:0] exp_rd;
        logic        exp_err;
        model_txn(we, a, wd, ws, exp_rd, exp_err);
        issue(we, a, wd, ws, ar1, aw1, w1);
        wait_resp(rd, err, lat);
        n_req++;
        chk("model_rdata", rd, exp_rd);
        chk("model_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        err, ar1, aw1, w1;
        int          lat;
        logic [3:0]  nib;
        for (int i = 0; i < 16; i++) mmem[i] = mem_init(i);
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0;

        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_valids_readies", 32'({bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
                                       bus.axi_wvalid, bus.axi_bready}), 32'd0);
        chk("rst_addr_data", bus.axi_araddr | bus.axi_awaddr | bus.axi_wdata, 32'd0);
        chk("rst_strb_prot", 32'({bus.axi_wstrb, bus.axi_arprot, bus.axi_awprot}), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Read, always-ready slave
        do_txn(1'b0, 32'h0000_bff8, 32'h0, 4'h0, rd, err, lat, ar1, aw1, w1);
        chk("rd_arvalid_n1", 32'(ar1), 32'd1);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_rdata", rd, 32'h1234_5678);
        chk("rd_err", 32'(err), 32'd0);

        // Write, awready delayed 3 cycles
        aw_delay = 3;
        do_txn(1'b1, 32'h0000_4000, 32'hdead_beef, 4'b0011, rd, err, lat, ar1, aw1, w1);
        chk("wr_aw_cycles", 32'(last_aw_hi), 32'd3);
        chk("wr_w_cycles", 32'(last_w_hi), 32'd1);
        chk("wr_latency_slow_aw", 32'(lat), 32'd5);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_rdata_zero", rd, 32'd0);
        aw_delay = 0;
        do_txn(1'b0, 32'h0000_4000, 32'h0, 4'h0, rd, err, lat, ar1, aw1, w1);
        chk("wr_readback", rd, (mem_init(0) & 32'hffff_0000) | 32'h0000_beef);

        // Write, always-ready
        do_txn(1'b1, 32'h0000_0104, 32'hcafe_f00d, 4'b1111, rd, err, lat, ar1, aw1, w1);
        chk("wr_awvalid_n1", 32'({aw1, w1}), 32'd3);
        chk("wr_latency", 32'(lat), 32'd3);

        // Error responses
        force_en = 1'b1; force_code = 2'b10;
        do_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, rd, err, lat, ar1, aw1, w1);
        chk("rd_slverr", 32'(err), 32'd1);
        force_code = 2'b11;
        do_txn(1'b1, 32'h0000_0008, 32'h1111_2222, 4'b1111, rd, err, lat, ar1, aw1, w1);
        chk("wr_decerr", 32'(err), 32'd1);
        chk("wr_decerr_rdata", rd, 32'd0);
        force_en = 1'b0;
        do_txn(1'b0, 32'hd000_0010, 32'h0, 4'h0, rd, err, lat, ar1, aw1, w1);
        chk("rd_exokay", 32'(err), 32'd0);

        // Random stall injection, mixed traffic, back-to-back requests
        rnd_mode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            case ($urandom_range(0, 4))
                0: nib = 4'h0;
                1: nib = 4'h1;
                2: nib = 4'hD;
                3: nib = 4'hE;
                default: nib = 4'hF;
            endcase
            a = {nib, 22'($urandom), 4'($urandom_range(0, 15)), 2'b00};
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   rd, err, lat, ar1, aw1, w1);
        end
        rnd_mode = 1'b0;

        // Reset in the middle of WR_REQ
        aw_delay = 1000;
        issue(1'b1, 32'h0000_2000, 32'h5555_aaaa, 4'b1111, ar1, aw1, w1);
        bus.req_valid = 1'b0;
        chk("pre_rst_awvalid", 32'(bus.axi_awvalid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_awvalid", 32'(bus.axi_awvalid), 32'd0);
        chk("rst_async_wvalid", 32'(bus.axi_wvalid), 32'd0);
        chk("rst_async_bready", 32'(bus.axi_bready), 32'd0);
        chk("rst_async_req_ready", 32'(bus.req_ready), 32'd1);
        have_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        aw_delay = 0;
        do_txn(1'b0, 32'h0000_2000, 32'h0, 4'h0, rd, err, lat, ar1, aw1, w1);
        chk("post_rst_rd_latency", 32'(lat), 32'd3);

        repeat (3) @(negedge clk);
        chk("resp_count", 32'(resp_cnt), 32'(n_req));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
